sig_unload: RTL and testbench

- Read-out end of the BIST signature path.
- Captures the compacted MISR signature when the scan controller reports scan_done.
- Serializes the signature to the external tester on a single framed serial pin (start, data MSB-first, even parity, stop) at a programmable bit period.
- Sits beside the compare logic in the BIST top; it is the off-chip reader for the on-chip signature writer.

---
 rtl/bist_pkg.sv | 23 ++
 rtl/sig_unload_if.sv | 35 +++
 rtl/sig_unload_bitdiv.sv | 28 ++
 rtl/sig_unload.sv | 148 ++++++++++++++
 tb/tb_sig_unload.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: signature width, serial frame levels and the unload FSM states.
// The PASSBIT state exists only when SIG_UNLOAD_PASS_EN is defined.
package bist_pkg;

    localparam int DEF_SIG_W = 13;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_START,
        ST_DATA,
`ifdef SIG_UNLOAD_PASS_EN
        ST_PASSBIT,
`endif
        ST_PAR,
        ST_STOP
    } sig_unload_state_e;

endpackage

// File: rtl/sig_unload_if.sv
// Signature unload bus: capture inputs from the scan side, framed serial output to the tester.
// Handshake: a capture is requested by a rising scan_done; unload_en only gates frame start.
interface sig_unload_if #(parameter int SIG_W = bist_pkg::DEF_SIG_W);
    import bist_pkg::*;

    logic             scan_done;
    logic [SIG_W-1:0] sig;
    logic             unload_en;
`ifdef SIG_UNLOAD_PASS_EN
    logic             pass;
`endif
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;
    logic             err;
    sig_unload_state_e dbg_state;

    modport master (
        output scan_done, sig, unload_en,
`ifdef SIG_UNLOAD_PASS_EN
        output pass,
`endif
        input  so, so_valid, busy, done, err, dbg_state
    );

    modport slave (
        input  scan_done, sig, unload_en,
`ifdef SIG_UNLOAD_PASS_EN
        input  pass,
`endif
        output so, so_valid, busy, done, err, dbg_state
    );

endinterface

// File: rtl/sig_unload_bitdiv.sv
// Bit-period divider: bit_tick marks the last cycle of each serial bit, restart holds it at bit start.
// With BIT_DIV=1 the counter never leaves 0, so every cycle is a bit boundary.
module sig_unload_bitdiv #(
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam logic [7:0] LAST = 8'(BIT_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (restart || bit_tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sig_unload.sv
// Captures the MISR signature on a rising scan_done and shifts it out as a framed serial word.
// Define SIG_UNLOAD_PASS_EN to append a captured pass bit (covered by parity) after the data.
module sig_unload #(
    parameter int SIG_W   = bist_pkg::DEF_SIG_W,
    parameter int BIT_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    sig_unload_if.slave  bus
);
    import bist_pkg::*;

    localparam int            CW       = $clog2(SIG_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SIG_W - 1);

    sig_unload_state_e state_q, state_d;
    logic [SIG_W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              par_q, par_d;
    logic              err_q, err_d;
    logic              scan_q;
`ifdef SIG_UNLOAD_PASS_EN
    logic              pass_q, pass_d;
`endif

    logic req, restart, bit_tick;
    logic so, so_valid, done;

    assign req     = bus.scan_done & ~scan_q;
    assign restart = (state_q == ST_IDLE) || (state_q == ST_HOLD);

    sig_unload_bitdiv #(.BIT_DIV(BIT_DIV)) u_bitdiv (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        // Any capture request outside IDLE is dropped and flagged until reset.
        err_d     = err_q | (req && (state_q != ST_IDLE));
`ifdef SIG_UNLOAD_PASS_EN
        pass_d    = pass_q;
`endif
        so        = IDLE_LEVEL;
        so_valid  = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    shreg_d   = bus.sig;
                    par_d     = 1'b0;
                    bit_cnt_d = '0;
`ifdef SIG_UNLOAD_PASS_EN
                    pass_d    = bus.pass;
`endif
                    state_d   = bus.unload_en ? ST_START : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.unload_en) state_d = ST_START;
            end
            ST_START: begin
                so       = FRAME_START;
                so_valid = 1'b1;
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                so       = shreg_q[SIG_W-1];
                so_valid = 1'b1;
                if (bit_tick) begin
                    shreg_d = {shreg_q[SIG_W-2:0], 1'b0};
                    par_d   = par_q ^ shreg_q[SIG_W-1];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SIG_UNLOAD_PASS_EN
                        state_d   = ST_PASSBIT;
`else
                        state_d   = ST_PAR;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef SIG_UNLOAD_PASS_EN
            ST_PASSBIT: begin
                so       = pass_q;
                so_valid = 1'b1;
                if (bit_tick) begin
                    par_d   = par_q ^ pass_q;
                    state_d = ST_PAR;
                end
            end
`endif
            ST_PAR: begin
                so       = par_q;
                so_valid = 1'b1;
                if (bit_tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                so       = FRAME_STOP;
                so_valid = 1'b1;
                if (bit_tick) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            err_q     <= 1'b0;
            scan_q    <= 1'b0;
`ifdef SIG_UNLOAD_PASS_EN
            pass_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            err_q     <= err_d;
            scan_q    <= bus.scan_done;
`ifdef SIG_UNLOAD_PASS_EN
            pass_q    <= pass_d;
`endif
        end
    end

    assign bus.so        = so;
    assign bus.so_valid  = so_valid;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sig_unload.sv
// Directed bench for sig_unload: BIT_DIV=4 instance for framing/hold/overrun/reset, BIT_DIV=1 instance for back-to-back bits.
// Expected frames are rebuilt from the signature value (start, MSB-first data, optional pass bit, even parity, stop).
module tb_sig_unload;
    import bist_pkg::*;

    localparam int SIG_W = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    sig_unload_if #(.SIG_W(SIG_W)) u_if ();
    sig_unload_if #(.SIG_W(SIG_W)) f_if ();

    sig_unload #(.SIG_W(SIG_W), .BIT_DIV(4)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
    sig_unload #(.SIG_W(SIG_W), .BIT_DIV(1)) f_dut (.clk(clk), .rst(rst), .bus(f_if));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {so, so_valid, busy, done} of the selected instance
    function automatic logic [3:0] obs(input int inst);
        if (inst == 1) return {f_if.so, f_if.so_valid, f_if.busy, f_if.done};
        return {u_if.so, u_if.so_valid, u_if.busy, u_if.done};
    endfunction

    function automatic logic err_of(input int inst);
        return (inst == 1) ? f_if.err : u_if.err;
    endfunction

    task automatic set_scan(input int inst, input logic v);
        if (inst == 1) f_if.scan_done = v;
        else           u_if.scan_done = v;
    endtask

    task automatic set_unload(input int inst, input logic v);
        if (inst == 1) f_if.unload_en = v;
        else           u_if.unload_en = v;
    endtask

    task automatic set_sig(input int inst, input logic [SIG_W-1:0] s, input logic p);
        if (inst == 1) f_if.sig = s;
        else           u_if.sig = s;
`ifdef SIG_UNLOAD_PASS_EN
        if (inst == 1) f_if.pass = p;
        else           u_if.pass = p;
`else
        if (p === 1'bx) $display("pass bit unknown");
`endif
    endtask

    task automatic run_frame(input int inst, input logic [SIG_W-1:0] s, input logic p,
                             input bit launch, input int ovr_at, input int abort_at,
                             input int drop_en_at);
        int   bd;
        int   n;
        logic par;
        bd = (inst == 1) ? 1 : 4;
        par = 1'b0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int b = SIG_W - 1; b >= 0; b--) begin
            exp_q.push_back(s[b]);
            par ^= s[b];
        end
`ifdef SIG_UNLOAD_PASS_EN
        exp_q.push_back(p);
        par ^= p;
`endif
        exp_q.push_back(par);
        exp_q.push_back(1'b1);
        n = exp_q.size() * bd;
        if (launch) begin
            @(negedge clk);
            set_sig(inst, s, p);
            set_scan(inst, 1'b1);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_outputs", obs(inst), 4'b1000);
                chk("abort_err", err_of(inst), 1'b0);
                set_scan(inst, 1'b0);
                @(negedge clk);
                chk("abort_no_done", obs(inst), 4'b1000);
                rst = 1'b0;
                return;
            end
            chk($sformatf("frame_i%0d_c%0d", inst, i), obs(inst),
                {exp_q[i / bd], 1'b1, 1'b1, (i == n - 1)});
            if (i == 0 && ovr_at >= 0) set_scan(inst, 1'b0);
            if (i == ovr_at) begin
                set_sig(inst, '1, ~p);
                set_scan(inst, 1'b1);
            end
            if (i == drop_en_at) set_unload(inst, 1'b0);
        end
        @(negedge clk);
        chk($sformatf("post_frame_i%0d", inst), obs(inst), 4'b1000);
        repeat (4) begin
            @(negedge clk);
            chk("no_retrigger", obs(inst), 4'b1000);
        end
        set_scan(inst, 1'b0);
    endtask

    initial begin
        u_if.scan_done = 1'b0; u_if.sig = '0; u_if.unload_en = 1'b1;
        f_if.scan_done = 1'b0; f_if.sig = '0; f_if.unload_en = 1'b1;
`ifdef SIG_UNLOAD_PASS_EN
        u_if.pass = 1'b0; f_if.pass = 1'b0;
`endif
        // reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", obs(0), 4'b1000);
        chk("reset_err", u_if.err, 1'b0);
        chk("reset_state", u_if.dbg_state, ST_IDLE);
        chk("reset_fast_outputs", obs(1), 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        chk("after_release", obs(0), 4'b1000);

        // basic frames, scan_done left high afterwards must not retrigger
        run_frame(0, 13'h1A5B, 1'b0, 1'b1, -1, -1, -1);
        run_frame(0, 13'h0001, 1'b0, 1'b1, -1, -1, -1);
        run_frame(0, 13'h0000, 1'b0, 1'b1, -1, -1, -1);
        chk("no_err_after_clean", u_if.err, 1'b0);

        // capture while tester is not ready: HOLD keeps the line idle
        @(negedge clk);
        set_unload(0, 1'b0);
        set_sig(0, 13'h1A5B, 1'b0);
        set_scan(0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("hold_c%0d", i), obs(0), 4'b1010);
        end
        chk("hold_state", u_if.dbg_state, ST_HOLD);
        set_unload(0, 1'b1);
        run_frame(0, 13'h1A5B, 1'b0, 1'b0, -1, -1, 8);
        set_unload(0, 1'b1);

        // second capture mid-frame: frame keeps the first signature, err sticks
        run_frame(0, 13'h1A5B, 1'b0, 1'b1, 20, -1, -1);
        chk("overrun_err", u_if.err, 1'b1);
        repeat (3) @(negedge clk);
        chk("overrun_err_sticky", u_if.err, 1'b1);

        // reset mid-frame, then a fresh complete frame
        run_frame(0, 13'h1A5B, 1'b0, 1'b1, -1, 30, -1);
        @(negedge clk);
        chk("post_abort_idle", obs(0), 4'b1000);
        run_frame(0, 13'h1A5B, 1'b0, 1'b1, -1, -1, -1);

        // one bit per cycle
        run_frame(1, 13'h1A5B, 1'b1, 1'b1, -1, -1, -1);
        chk("fast_err", f_if.err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
